fwd_hazard_unit: RTL
====================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width.
REQ-002 SHALL have parameter RW, default 5, register-number width.
REQ-003 SHALL have parameter CW, default 16, stall-counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 rs, rt  in  RW each  ID-stage source register numbers.
REQ-008 use_rs, use_rt  in  1 each  ID instruction reads rs / rt.
REQ-009 qa, qb  in  WIDTH each  register-file read data.
REQ-010 ewreg, em2reg, ern  in  1, 1, RW  EX-stage write enable, load flag, destination.
REQ-011 r  in  WIDTH  EX ALU result.
REQ-012 mwreg, mm2reg, mrn  in  1, 1, RW  MEM-stage write enable, load flag, destination.
REQ-013 mr, do  in  WIDTH each  MEM ALU result and memory read data.
REQ-014 flush  in  1  squash the ID instruction (branch taken).
REQ-015 fwda, fwdb  out  2 each  select codes.
REQ-016 stall  out  1  hold PC and IF/ID.
REQ-017 ea, eb  out  WIDTH each  registered ID/EX operands.
REQ-018 ebubble  out  1  ID/EX holds a bubble.
REQ-019 stall_cnt  out  CW  saturating count of load-use stalls.

Function
REQ-020 Select codes, combinational: 00 = qx, 01 = r, 10 = mr, 11 = do.
REQ-021 fwda = 01 when ewreg, !em2reg, ern!=0 and ern==rs.
REQ-022 Otherwise, fwda = 10 when mwreg, !mm2reg, mrn!=0 and mrn==rs.
REQ-023 Otherwise, fwda = 11 when mwreg, mm2reg, mrn!=0 and mrn==rs.
REQ-024 Otherwise, fwda = 00.
REQ-025 fwdb SHALL follow REQ-021..024 using rt.
REQ-026 EX SHALL take priority over MEM, so the youngest producer wins.
REQ-027 Register 0 SHALL never be forwarded or cause a stall.
REQ-028 stall SHALL be 1, combinationally, when ewreg, em2reg, ern!=0, and ((use_rs and ern==rs) or (use_rt and ern==rt)), and the FSM state is RUN.
REQ-029 FSM states: RUN, STALL.
REQ-030 RUN->STALL when stall=1 and flush=0.
REQ-031 STALL->RUN unconditionally after one cycle; stall SHALL be forced to 0 in STALL.
REQ-032 Each load SHALL therefore cause at most one bubble.
REQ-033 On each rising edge with stall=1 or flush=1: ea, eb SHALL be set to 0 and ebubble to 1.
REQ-034 Otherwise on each rising edge: ea SHALL load the fwda-selected value, eb the fwdb-selected value, and ebubble 0.
REQ-035 flush together with stall: flush wins, the state stays RUN and stall_cnt does not increment.
REQ-036 stall_cnt SHALL increment by 1 on each RUN->STALL transition.
REQ-037 stall_cnt SHALL saturate at 2^CW-1 with no wrap.
REQ-038 Operand latency SHALL be one cycle from ID inputs to ea/eb.

Reset
REQ-039 On rst: state=RUN, ea=0, eb=0, ebubble=1, stall_cnt=0.
REQ-040 rst SHALL override flush and stall in the same cycle.
REQ-041 rst asserted mid-STALL SHALL return the FSM to RUN on the next edge.
REQ-042 fwda/fwdb/stall SHALL remain combinational functions of the inputs during reset; stall SHALL be masked to 0 while rst=1.

Structure
REQ-043 Select codes FWD_REG/FWD_EXALU/FWD_MEMALU/FWD_MEMDO and FSM state encodings SHALL live in the shared pipeline package.
REQ-044 One sub-module, fwd_sel (per-operand compare plus 4:1 WIDTH mux), SHALL be instantiated twice (rs/qa, rt/qb).
REQ-045 The selection mux SHALL be full-case with no latches.

Verification
REQ-046 rs=3, ewreg=1, em2reg=0, ern=3, r=0xAAAA0001 -> fwda=01; ea=0xAAAA0001 after one edge.
REQ-047 rt=4, ern=4 (ALU), mrn=4 (load), do=0x55 -> fwdb=01 (EX priority); eb=r.
REQ-048 Load ern=7, use_rs=1, rs=7 -> stall=1 for exactly one cycle, ebubble=1, stall_cnt=1; next cycle fwda=11, ea=do.
REQ-049 rs=0, ern=0, ewreg=1 -> fwda=00, stall=0.
REQ-050 Load-use hazard with flush=1 -> stall_cnt unchanged, state RUN, ebubble=1.
REQ-051 CW=2 with 5 load-use stalls -> stall_cnt=3; assert rst during STALL -> state RUN, outputs per REQ-039.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions: operand select codes and hazard FSM states.
package fwd_hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_EXALU  = 2'b01,
    FWD_MEMALU = 2'b10,
    FWD_MEMDO  = 2'b11
  } fwd_code_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// Per-operand forwarding: compare one source register against the EX/MEM
// destinations and pick the youngest producer's value.
module fwd_sel #(
  parameter int WIDTH = 32,
  parameter int RW    = 5
) (
  input  logic [RW-1:0]    src,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [RW-1:0]    ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [RW-1:0]    mrn,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] mr,
  input  logic [WIDTH-1:0] mdo,
  output logic [1:0]       fwd,
  output logic [WIDTH-1:0] val
);
  import fwd_hazard_unit_pkg::*;

  logic      src_nz;
  logic      ex_hit;
  logic      mem_hit;
  fwd_code_t code;

  // An EX load cannot forward yet; it falls through so an older MEM producer may still match.
  always_comb begin
    src_nz  = (src != '0);
    ex_hit  = ewreg && !em2reg && src_nz && (ern == src);
    mem_hit = mwreg && src_nz && (mrn == src);
    code    = FWD_REG;
    if (ex_hit)
      code = FWD_EXALU;
    else if (mem_hit && !mm2reg)
      code = FWD_MEMALU;
    else if (mem_hit)
      code = FWD_MEMDO;
  end

  always_comb begin
    val = q;
    case (code)
      FWD_REG:    val = q;
      FWD_EXALU:  val = r;
      FWD_MEMALU: val = mr;
      FWD_MEMDO:  val = mdo;
      default:    val = q;
    endcase
  end

  assign fwd = code;

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding and load-use hazard unit with registered ID/EX operands.
// The MEM read-data input is named mdo because "do" is a reserved word.
module fwd_hazard_unit #(
  parameter int WIDTH = 32,
  parameter int RW    = 5,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    rs,
  input  logic [RW-1:0]    rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [WIDTH-1:0] qa,
  input  logic [WIDTH-1:0] qb,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [RW-1:0]    ern,
  input  logic [WIDTH-1:0] r,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [RW-1:0]    mrn,
  input  logic [WIDTH-1:0] mr,
  input  logic [WIDTH-1:0] mdo,
  input  logic             flush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             stall,
  output logic [WIDTH-1:0] ea,
  output logic [WIDTH-1:0] eb,
  output logic             ebubble,
  output logic [CW-1:0]    stall_cnt
);
  import fwd_hazard_unit_pkg::*;

  logic [RW-1:0]    op_rn  [2];
  logic [WIDTH-1:0] op_q   [2];
  logic [WIDTH-1:0] op_val [2];
  logic [1:0]       op_fwd [2];

  hz_state_t        state_reg, state_next;
  logic             load_use;
  logic [WIDTH-1:0] ea_reg, eb_reg;
  logic             ebubble_reg;
  logic [CW-1:0]    stall_cnt_reg;

  assign op_rn[0] = rs;
  assign op_rn[1] = rt;
  assign op_q[0]  = qa;
  assign op_q[1]  = qb;

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    fwd_sel #(
      .WIDTH(WIDTH),
      .RW   (RW)
    ) u_fwd_sel (
      .src   (op_rn[gi]),
      .ewreg (ewreg),
      .em2reg(em2reg),
      .ern   (ern),
      .mwreg (mwreg),
      .mm2reg(mm2reg),
      .mrn   (mrn),
      .q     (op_q[gi]),
      .r     (r),
      .mr    (mr),
      .mdo   (mdo),
      .fwd   (op_fwd[gi]),
      .val   (op_val[gi])
    );
  end

  assign fwda = op_fwd[0];
  assign fwdb = op_fwd[1];

  // A load in EX feeding a used source needs one bubble before it reaches MEM.
  always_comb begin
    load_use   = ewreg && em2reg && (ern != '0) &&
                 ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));
    stall      = 1'b0;
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        stall = load_use && !rst;
        if (stall && !flush)
          state_next = STALL;
      end
      STALL:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      ea_reg        <= '0;
      eb_reg        <= '0;
      ebubble_reg   <= 1'b1;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (stall || flush) begin
        ea_reg      <= '0;
        eb_reg      <= '0;
        ebubble_reg <= 1'b1;
      end else begin
        ea_reg      <= op_val[0];
        eb_reg      <= op_val[1];
        ebubble_reg <= 1'b0;
      end
      if (state_reg == RUN && state_next == STALL && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign ea        = ea_reg;
  assign eb        = eb_reg;
  assign ebubble   = ebubble_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
